// File: rtl/enc_onehot_pipe.sv
// enc_onehot_pipe: parametrised N-to-log2(N) encoder with valid/ready
// handshakes and a 2-entry output buffer.
// Each accepted vector becomes {idx, zero, multi}. Zero flags an all-zero
// vector, and multi flags two or more set bits.
// Optional feature macro ENC_ROUND_ROBIN_EN: multi-hot vectors are resolved
// round-robin from a rotating pointer instead of lowest-index-wins.
module enc_onehot_pipe #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_zero,
  output logic         out_multi
);

  typedef struct packed {
    logic [W-1:0] idx;
    logic         zero;
    logic         multi;
  } entry_t;

  entry_t     enc_entry;
  entry_t     head_q;
  entry_t     tail_q;
  logic [1:0] count_q;
  logic       push;
  logic       pop;
  logic       seen;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_idx   = head_q.idx;
  assign out_zero  = head_q.zero;
  assign out_multi = head_q.multi;

`ifdef ENC_ROUND_ROBIN_EN
  logic [W-1:0] rr_ptr;
  logic         rr_found;
  logic [W:0]   rr_pos_wide;
  logic [W-1:0] rr_pos;

  // Rotating search start: advances past the winner of each non-zero vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (push && !enc_entry.zero) begin
      if (enc_entry.idx == W'(N - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= enc_entry.idx + W'(1);
      end
    end
  end
`endif

  // Encode the incoming vector: count set bits for zero/multi, then pick the winner
  always_comb begin
    enc_entry = '0;
    seen      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_vec[i]) begin
        if (seen) begin
          enc_entry.multi = 1'b1;
        end
        seen = 1'b1;
      end
    end
    enc_entry.zero = !seen;
`ifdef ENC_ROUND_ROBIN_EN
    rr_found    = 1'b0;
    rr_pos_wide = '0;
    rr_pos      = '0;
    for (int k = 0; k < N; k++) begin
      rr_pos_wide = {1'b0, rr_ptr} + (W+1)'(k);
      if (rr_pos_wide >= (W+1)'(N)) begin
        rr_pos_wide = rr_pos_wide - (W+1)'(N);
      end
      rr_pos = rr_pos_wide[W-1:0];
      if (!rr_found && in_vec[rr_pos]) begin
        enc_entry.idx = rr_pos;
        rr_found      = 1'b1;
      end
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (in_vec[i]) begin
        enc_entry.idx = W'(i);
      end
    end
`endif
  end

  // Two-entry buffer: head drives the outputs, tail holds the second result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q <= enc_entry;
          end else begin
            tail_q <= enc_entry;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          tail_q  <= '0;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop only happens with one entry buffered
          head_q <= enc_entry;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_onehot_pipe.sv
// tb_enc_onehot_pipe: directed scenarios plus randomized traffic for
// enc_onehot_pipe (N=8), checked against a queue-based reference model.
// The same ENC_ROUND_ROBIN_EN define selects the model's priority rule.
module tb_enc_onehot_pipe;

  localparam int N = 8;
  localparam int W = 3;

  typedef struct packed {
    logic [W-1:0] idx;
    logic         zero;
    logic         multi;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_vec = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_idx;
  logic         out_zero;
  logic         out_multi;

  wire  [W+2:0] obs = {out_valid, out_idx, out_zero, out_multi};

  ent_t mq[$];
  int   rr_p = 0;
  int   checks = 0;
  int   failures = 0;

  enc_onehot_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_zero  (out_zero),
    .out_multi (out_multi)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference encoding: rotate so the search start sits at bit 0, then isolate the lowest set bit
  function automatic ent_t model_enc(input logic [N-1:0] v, input int p);
    ent_t           e;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   r;
    logic [N-1:0]   low;
    int             base;
    e = '0;
    if (v == '0) begin
      e.zero = 1'b1;
      return e;
    end
    e.multi = ($countones(v) > 1);
`ifdef ENC_ROUND_ROBIN_EN
    base = p;
`else
    base = 0;
`endif
    dbl = {v, v};
    r   = N'(dbl >> base);
    low = r & (~r + N'(1));
    e.idx = W'((base + $clog2(low)) % N);
    return e;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs, then step the DUT
  task automatic tick();
    bit   push;
    bit   pop;
    ent_t e;
    push = in_valid && (mq.size() != 2);
    pop  = (mq.size() != 0) && out_ready;
    if (pop) void'(mq.pop_front());
    if (push) begin
      e = model_enc(in_vec, rr_p);
      mq.push_back(e);
      if (!e.zero) rr_p = (int'(e.idx) + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    mq.delete();
    rr_p = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({obs, in_ready} !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_values got={valid,idx,zero,multi,ready}=%b exp=%b", {obs, in_ready}, 7'b0000001);
    end
    do_reset();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL reset_release got={valid,ready}=%b exp=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_walk();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_vec = N'(1) << i;
      tick();
      checks++;
      if (obs !== {1'b1, W'(i), 1'b0, 1'b0}) begin
        failures++;
        $display("[TB] FAIL walk_bit%0d got=%b exp=%b", i, obs, {1'b1, W'(i), 2'b00});
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL walk_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_zero_multi();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 8'h00;
    tick();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL zero_vec got=%b exp=%b", obs, 6'b100010);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 8'hA4;
    tick();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd2, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL multi_A4 got=%b exp=%b", obs, 6'b101001);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 8'h02;
    tick();
    checks++;
    if ({obs, in_ready} !== {1'b1, 3'd1, 2'b00, 1'b1}) begin
      failures++;
      $display("[TB] FAIL bp_first got=%b exp=%b", {obs, in_ready}, 7'b1001001);
    end
    in_vec = 8'h10;
    tick();
    checks++;
    if ({obs, in_ready} !== {1'b1, 3'd1, 2'b00, 1'b0}) begin
      failures++;
      $display("[TB] FAIL bp_full got=%b exp=%b", {obs, in_ready}, 7'b1001000);
    end
    in_vec = 8'h40;
    tick();
    checks++;
    if ({obs, in_ready} !== {1'b1, 3'd1, 2'b00, 1'b0}) begin
      failures++;
      $display("[TB] FAIL bp_no_overwrite got=%b exp=%b", {obs, in_ready}, 7'b1001000);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({obs, in_ready} !== {1'b1, 3'd4, 2'b00, 1'b1}) begin
      failures++;
      $display("[TB] FAIL bp_pop1 got=%b exp=%b", {obs, in_ready}, 7'b1100001);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({obs, in_ready} !== {1'b1, 3'd6, 2'b00, 1'b1}) begin
      failures++;
      $display("[TB] FAIL bp_late_accept got=%b exp=%b", {obs, in_ready}, 7'b1110001);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 8'h08;
    tick();
    in_vec    = 8'h20;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({obs, in_ready} !== {1'b1, 3'd5, 2'b00, 1'b1}) begin
      failures++;
      $display("[TB] FAIL pushpop_count1 got=%b exp=%b", {obs, in_ready}, 7'b1101001);
    end
    tick();
    checks++;
    if (obs !== {1'b1, 3'd5, 2'b00}) begin
      failures++;
      $display("[TB] FAIL pushpop_hold got=%b exp=%b", obs, 6'b110100);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pushpop_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 8'h04;
    tick();
    in_vec = 8'h80;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL rstmid_full got={valid,ready}=%b exp=10", {out_valid, in_ready});
    end
    #2;
    rst_n = 1'b0;
    mq.delete();
    rr_p = 0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL rstmid_async got={valid,ready}=%b exp=01", {out_valid, in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 8'h08;
    tick();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd3, 2'b00}) begin
      failures++;
      $display("[TB] FAIL rstmid_next got=%b exp=%b", obs, 6'b101100);
    end
    tick();
  endtask

`ifdef ENC_ROUND_ROBIN_EN
  task automatic test_rr();
    logic [W+2:0] exp_seq [5];
    logic [N-1:0] vec_seq [5];
    exp_seq[0] = {1'b1, 3'd0, 2'b01};
    exp_seq[1] = {1'b1, 3'd4, 2'b01};
    exp_seq[2] = {1'b1, 3'd0, 2'b01};
    exp_seq[3] = {1'b1, 3'd0, 2'b10};
    exp_seq[4] = {1'b1, 3'd4, 2'b01};
    vec_seq[0] = 8'h11;
    vec_seq[1] = 8'h11;
    vec_seq[2] = 8'h11;
    vec_seq[3] = 8'h00;
    vec_seq[4] = 8'h11;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_vec = vec_seq[i];
      tick();
      checks++;
      if (obs !== exp_seq[i]) begin
        failures++;
        $display("[TB] FAIL rr_step%0d got=%b exp=%b", i, obs, exp_seq[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    int kind;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      kind     = $urandom_range(0, 3);
      if (kind == 0) begin
        in_vec = '0;
      end else if (kind == 1) begin
        in_vec = N'(1) << $urandom_range(0, N - 1);
      end else begin
        in_vec = N'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 6);
      checks++;
      if (in_ready !== (mq.size() != 2)) begin
        failures++;
        $display("[TB] FAIL rand_ready cyc=%0d got=%b exp=%b", c, in_ready, (mq.size() != 2));
      end
      checks++;
      if (mq.size() == 0) begin
        if (out_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL rand_empty cyc=%0d got out_valid=%b exp=0", c, out_valid);
        end
      end else if (obs !== {1'b1, mq[0]}) begin
        failures++;
        $display("[TB] FAIL rand_head cyc=%0d got=%b exp=%b", c, obs, {1'b1, mq[0]});
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  // Safety net in case the simulation stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence
  initial begin
    test_reset();
    test_walk();
    test_zero_multi();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
`ifdef ENC_ROUND_ROBIN_EN
    test_rr();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
